// File: rtl/local_bus_pkg.sv
// Shared types and constants for the local IO bus arbiter.
// Optional feature macro: LOCAL_BUS_ARB_TIMEOUT_EN (BUSY timeout counter).
package local_bus_pkg;

    // Arbiter transaction state
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_ACK  = 2'd2
    } state_t;

    // Target select codes carried in address bits [9:8]
    typedef enum logic [1:0] {
        SEL_GPIO = 2'd0,
        SEL_DISP = 2'd1,
        SEL_UART = 2'd2,
        SEL_NONE = 2'd3
    } sel_t;

    localparam int                   TIMEOUT_W   = 10;
    localparam logic [TIMEOUT_W-1:0] TIMEOUT_MAX = 10'd1023;

    // Chip-select vector {uart, disp, gpio}; the unmapped code selects nothing
    function automatic logic [2:0] sel_to_cs(input sel_t sel);
        logic [2:0] cs;
        cs = 3'b000;
        case (sel)
            SEL_GPIO: cs = 3'b001;
            SEL_DISP: cs = 3'b010;
            SEL_UART: cs = 3'b100;
            default:  cs = 3'b000;
        endcase
        return cs;
    endfunction

endpackage

// File: rtl/local_bus_rr_arb.sv
// Two-master round-robin grant. The grant is combinational from the live
// requests; the priority pointer moves only when a transaction completes,
// so the master that was not served last wins a tie.
module local_bus_rr_arb
    import local_bus_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] i_req,
    input  logic       i_upd,
    input  logic [1:0] i_upd_gnt,
    output logic [1:0] o_gnt
);

    // 1 = m1 wins the next tie, 0 = m0 wins
    logic r_prio_m1;

    // Priority pointer: after serving m0, m1 gets the tie; after m1, m0 does
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_prio_m1 <= 1'b0;
        end else if (i_upd) begin
            r_prio_m1 <= i_upd_gnt[0];
        end
    end

    // One-hot grant from the current requests and the pointer
    always_comb begin
        o_gnt = 2'b00;
        case (i_req)
            2'b01:   o_gnt = 2'b01;
            2'b10:   o_gnt = 2'b10;
            2'b11:   o_gnt = r_prio_m1 ? 2'b10 : 2'b01;
            default: o_gnt = 2'b00;
        endcase
    end

endmodule

// File: rtl/local_bus_arb.sv
// Local IO bus arbiter: two masters share one bus to gpio/disp/uart.
// One transaction at a time: IDLE -> BUSY (bus driven, wait for rdy) ->
// ACK (one-cycle ack to the granted master) -> IDLE. All outputs registered.
// Optional feature macro: LOCAL_BUS_ARB_TIMEOUT_EN. When defined, a 10-bit
// counter aborts a BUSY phase with err=1 after TIMEOUT_MAX cycles without rdy
// (unmapped select included). When undefined, an unmapped select completes
// with err=1 after a single BUSY cycle and mapped targets wait for rdy forever.
module local_bus_arb
    import local_bus_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    // master 0
    input  logic       m0_req,
    input  logic       m0_rnw,
    input  logic [9:0] m0_addr,
    input  logic [7:0] m0_wr_data,
    output logic       m0_ack,
    output logic       m0_err,
    output logic [7:0] m0_rd_data,
    // master 1
    input  logic       m1_req,
    input  logic       m1_rnw,
    input  logic [9:0] m1_addr,
    input  logic [7:0] m1_wr_data,
    output logic       m1_ack,
    output logic       m1_err,
    output logic [7:0] m1_rd_data,
    // local IO bus
    output logic [7:0] addr,
    output logic       rnw,
    output logic       req,
    output logic [7:0] wr_data,
    output logic       gpio_cs,
    output logic       disp_cs,
    output logic       uart_cs,
    input  logic       gpio_rdy,
    input  logic       disp_rdy,
    input  logic       uart_rdy,
    input  logic [7:0] gpio_rd_data,
    input  logic [7:0] disp_rd_data,
    input  logic [7:0] uart_rd_data
);

    state_t     r_state;
    logic [1:0] r_gnt;
    sel_t       r_sel;
    logic [7:0] r_addr;
    logic       r_rnw;
    logic [7:0] r_wr_data;
    logic       r_req;
    logic [2:0] r_cs;
    logic       r_m0_ack;
    logic       r_m0_err;
    logic [7:0] r_m0_rd_data;
    logic       r_m1_ack;
    logic       r_m1_err;
    logic [7:0] r_m1_rd_data;

    logic [1:0] w_gnt;
    logic       w_upd;
    logic       w_sel_rdy;
    logic [7:0] w_sel_rd_data;
    logic       w_done;
    logic       w_done_err;
    logic [7:0] w_done_rd;
    sel_t       w_new_sel;

`ifdef LOCAL_BUS_ARB_TIMEOUT_EN
    logic [TIMEOUT_W-1:0] r_cnt;
    logic [TIMEOUT_W-1:0] w_cnt_inc;
    assign w_cnt_inc = r_cnt + 1'b1;
`endif

    // Pointer advances on the edge leaving ACK, once the transaction is done
    assign w_upd = (r_state == ST_ACK);

    local_bus_rr_arb u_rr (
        .clk       (clk),
        .reset     (reset),
        .i_req     ({m1_req, m0_req}),
        .i_upd     (w_upd),
        .i_upd_gnt (r_gnt),
        .o_gnt     (w_gnt)
    );

    assign w_new_sel = w_gnt[1] ? sel_t'(m1_addr[9:8]) : sel_t'(m0_addr[9:8]);

    // Only the latched target's rdy/rd_data are looked at; others are ignored
    always_comb begin
        w_sel_rdy     = 1'b0;
        w_sel_rd_data = 8'h00;
        case (r_sel)
            SEL_GPIO: begin
                w_sel_rdy     = gpio_rdy;
                w_sel_rd_data = gpio_rd_data;
            end
            SEL_DISP: begin
                w_sel_rdy     = disp_rdy;
                w_sel_rd_data = disp_rd_data;
            end
            SEL_UART: begin
                w_sel_rdy     = uart_rdy;
                w_sel_rd_data = uart_rd_data;
            end
            default: begin
                w_sel_rdy     = 1'b0;
                w_sel_rd_data = 8'h00;
            end
        endcase
    end

    // Decide whether the BUSY phase ends this cycle and with what result
    always_comb begin
        w_done     = 1'b0;
        w_done_err = 1'b0;
        w_done_rd  = 8'h00;
        if (r_state == ST_BUSY) begin
            if (w_sel_rdy) begin
                w_done    = 1'b1;
                // writes return zero data
                w_done_rd = r_rnw ? w_sel_rd_data : 8'h00;
`ifdef LOCAL_BUS_ARB_TIMEOUT_EN
            end else if (w_cnt_inc == TIMEOUT_MAX) begin
                w_done     = 1'b1;
                w_done_err = 1'b1;
`else
            end else if (r_sel == SEL_NONE) begin
                w_done     = 1'b1;
                w_done_err = 1'b1;
`endif
            end
        end
    end

    // Transaction FSM with registered bus and master-side outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_gnt        <= 2'b00;
            r_sel        <= SEL_GPIO;
            r_addr       <= 8'h00;
            r_rnw        <= 1'b0;
            r_wr_data    <= 8'h00;
            r_req        <= 1'b0;
            r_cs         <= 3'b000;
            r_m0_ack     <= 1'b0;
            r_m0_err     <= 1'b0;
            r_m0_rd_data <= 8'h00;
            r_m1_ack     <= 1'b0;
            r_m1_err     <= 1'b0;
            r_m1_rd_data <= 8'h00;
`ifdef LOCAL_BUS_ARB_TIMEOUT_EN
            r_cnt        <= '0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (|w_gnt) begin
                        r_state   <= ST_BUSY;
                        r_gnt     <= w_gnt;
                        r_sel     <= w_new_sel;
                        r_addr    <= w_gnt[1] ? m1_addr[7:0] : m0_addr[7:0];
                        r_rnw     <= w_gnt[1] ? m1_rnw : m0_rnw;
                        r_wr_data <= w_gnt[1] ? m1_wr_data : m0_wr_data;
                        r_req     <= 1'b1;
                        r_cs      <= sel_to_cs(w_new_sel);
`ifdef LOCAL_BUS_ARB_TIMEOUT_EN
                        r_cnt     <= '0;
`endif
                    end
                end
                ST_BUSY: begin
`ifdef LOCAL_BUS_ARB_TIMEOUT_EN
                    r_cnt <= w_cnt_inc;
`endif
                    if (w_done) begin
                        r_state      <= ST_ACK;
                        r_req        <= 1'b0;
                        r_cs         <= 3'b000;
                        r_m0_ack     <= r_gnt[0];
                        r_m0_err     <= r_gnt[0] & w_done_err;
                        r_m0_rd_data <= r_gnt[0] ? w_done_rd : 8'h00;
                        r_m1_ack     <= r_gnt[1];
                        r_m1_err     <= r_gnt[1] & w_done_err;
                        r_m1_rd_data <= r_gnt[1] ? w_done_rd : 8'h00;
                    end
                end
                ST_ACK: begin
                    // ack is a single-cycle pulse; results are cleared with it
                    r_state      <= ST_IDLE;
                    r_gnt        <= 2'b00;
                    r_m0_ack     <= 1'b0;
                    r_m0_err     <= 1'b0;
                    r_m0_rd_data <= 8'h00;
                    r_m1_ack     <= 1'b0;
                    r_m1_err     <= 1'b0;
                    r_m1_rd_data <= 8'h00;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign addr       = r_addr;
    assign rnw        = r_rnw;
    assign req        = r_req;
    assign wr_data    = r_wr_data;
    assign gpio_cs    = r_cs[0];
    assign disp_cs    = r_cs[1];
    assign uart_cs    = r_cs[2];
    assign m0_ack     = r_m0_ack;
    assign m0_err     = r_m0_err;
    assign m0_rd_data = r_m0_rd_data;
    assign m1_ack     = r_m1_ack;
    assign m1_err     = r_m1_err;
    assign m1_rd_data = r_m1_rd_data;

endmodule

// File: tb/tb_local_bus_arb.sv
// Self-checking bench for local_bus_arb. A transaction-level reference model
// predicts grant order and the cycle-by-cycle timeline of each round
// (BUSY cycles, one ACK cycle, one IDLE cycle) from the target delays it
// chooses itself. Honors LOCAL_BUS_ARB_TIMEOUT_EN for the unmapped case.
module tb_local_bus_arb;

    logic       clk = 1'b0;
    logic       reset;
    logic       m0_req, m0_rnw, m1_req, m1_rnw;
    logic [9:0] m0_addr, m1_addr;
    logic [7:0] m0_wr_data, m1_wr_data;
    logic       m0_ack, m0_err, m1_ack, m1_err;
    logic [7:0] m0_rd_data, m1_rd_data;
    logic [7:0] addr, wr_data;
    logic       rnw, req;
    logic       gpio_cs, disp_cs, uart_cs;
    logic       gpio_rdy, disp_rdy, uart_rdy;
    logic [7:0] gpio_rd_data, disp_rd_data, uart_rd_data;

    local_bus_arb dut (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m0_rnw(m0_rnw), .m0_addr(m0_addr), .m0_wr_data(m0_wr_data),
        .m0_ack(m0_ack), .m0_err(m0_err), .m0_rd_data(m0_rd_data),
        .m1_req(m1_req), .m1_rnw(m1_rnw), .m1_addr(m1_addr), .m1_wr_data(m1_wr_data),
        .m1_ack(m1_ack), .m1_err(m1_err), .m1_rd_data(m1_rd_data),
        .addr(addr), .rnw(rnw), .req(req), .wr_data(wr_data),
        .gpio_cs(gpio_cs), .disp_cs(disp_cs), .uart_cs(uart_cs),
        .gpio_rdy(gpio_rdy), .disp_rdy(disp_rdy), .uart_rdy(uart_rdy),
        .gpio_rd_data(gpio_rd_data), .disp_rd_data(disp_rd_data), .uart_rd_data(uart_rd_data)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       rnw;
        logic [9:0] addr;
        logic [7:0] wd;
        logic [3:0] d;      // BUSY cycles the target waits before rdy
    } tx_t;

    int         n_checks = 0;
    int         n_pass   = 0;
    int         prio_m1  = 0;   // model: 1 when m1 wins the next tie
    logic [7:0] tgt_rd [3];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic tx_t mk(input logic rnw_i, input logic [9:0] a, input logic [7:0] wd, input int d);
        tx_t t;
        t.rnw = rnw_i; t.addr = a; t.wd = wd; t.d = 4'(d);
        return t;
    endfunction

    function automatic tx_t rand_tx();
        return mk(1'($urandom), 10'($urandom), 8'($urandom), int'($urandom_range(0, 3)));
    endfunction

    function automatic int busy_len(input tx_t t);
        if (t.addr[9:8] == 2'd3) begin
`ifdef LOCAL_BUS_ARB_TIMEOUT_EN
            return 1023;
`else
            return 1;
`endif
        end
        return int'(t.d) + 1;
    endfunction

    function automatic logic [2:0] exp_cs(input logic [1:0] sel);
        logic [2:0] v;
        v = 3'b000;
        if (sel != 2'd3) v[sel] = 1'b1;
        return v;
    endfunction

    function automatic logic [9:0] mout(input int m);
        return (m == 0) ? {m0_ack, m0_err, m0_rd_data} : {m1_ack, m1_err, m1_rd_data};
    endfunction

    task automatic set_m(input int m, input logic rq, input tx_t t);
        if (m == 0) begin
            m0_req = rq; m0_rnw = t.rnw; m0_addr = t.addr; m0_wr_data = t.wd;
        end else begin
            m1_req = rq; m1_rnw = t.rnw; m1_addr = t.addr; m1_wr_data = t.wd;
        end
    endtask

    // Selected target gets 'on'; every other rdy is noise
    task automatic drive_rdy(input logic [1:0] sel, input logic on);
        gpio_rdy = (sel == 2'd0) ? on : 1'($urandom);
        disp_rdy = (sel == 2'd1) ? on : 1'($urandom);
        uart_rdy = (sel == 2'd2) ? on : 1'($urandom);
    endtask

    task automatic new_targets();
        for (int i = 0; i < 3; i++) tgt_rd[i] = 8'($urandom);
    endtask

    task automatic run_round(input logic [1:0] mask, input tx_t t0, input tx_t t1);
        tx_t        tq [2];
        int         gs [2];
        int         ng;
        int         g, n;
        logic [1:0] sel;
        logic [7:0] erd;
        tq[0] = t0; tq[1] = t1;
        gpio_rd_data = tgt_rd[0]; disp_rd_data = tgt_rd[1]; uart_rd_data = tgt_rd[2];
        drive_rdy(2'd3, 1'b0);
        set_m(0, mask[0], t0);
        set_m(1, mask[1], t1);
        if (mask == 2'b11) begin
            gs[0] = prio_m1; gs[1] = 1 - prio_m1; ng = 2;
        end else begin
            gs[0] = mask[1] ? 1 : 0; gs[1] = 0; ng = 1;
        end
        for (int j = 0; j < ng; j++) begin
            g   = gs[j];
            n   = busy_len(tq[g]);
            sel = tq[g].addr[9:8];
            for (int k = 0; k < n; k++) begin
                step();
                check("busy_req", 32'(req), 32'd1);
                check("busy_cs", 32'({uart_cs, disp_cs, gpio_cs}), 32'(exp_cs(sel)));
                check("busy_addr", 32'(addr), 32'(tq[g].addr[7:0]));
                check("busy_rnw", 32'(rnw), 32'(tq[g].rnw));
                check("busy_wdata", 32'(wr_data), 32'(tq[g].wd));
                check("busy_m0", 32'(mout(0)), 32'd0);
                check("busy_m1", 32'(mout(1)), 32'd0);
                drive_rdy(sel, 1'(k >= int'(tq[g].d)));
                // latched values must not follow the master's inputs
                set_m(g, 1'b1, rand_tx());
            end
            step();
            erd = (sel != 2'd3 && tq[g].rnw) ? tgt_rd[sel] : 8'h00;
            check("ack_req", 32'(req), 32'd0);
            check("ack_cs", 32'({uart_cs, disp_cs, gpio_cs}), 32'd0);
            check(g == 0 ? "ack_m0" : "ack_m1", 32'(mout(g)), 32'({1'b1, 1'(sel == 2'd3), erd}));
            check(g == 0 ? "ack_idle_m1" : "ack_idle_m0", 32'(mout(1 - g)), 32'd0);
            set_m(g, 1'b0, tq[g]);
            prio_m1 = (g == 0) ? 1 : 0;
            drive_rdy(2'd3, 1'b0);
            step();
            check("idle_req", 32'(req), 32'd0);
            check("idle_cs", 32'({uart_cs, disp_cs, gpio_cs}), 32'd0);
            check("idle_m0", 32'(mout(0)), 32'd0);
            check("idle_m1", 32'(mout(1)), 32'd0);
        end
    endtask

    initial begin
        reset = 1'b1;
        set_m(0, 1'b1, mk(1'b1, 10'h012, 8'h00, 0));
        set_m(1, 1'b0, mk(1'b0, 10'h000, 8'h00, 0));
        gpio_rdy = 1'b1; disp_rdy = 1'b0; uart_rdy = 1'b0;
        gpio_rd_data = 8'h00; disp_rd_data = 8'h00; uart_rd_data = 8'h00;
        // outputs held at zero while reset is high, even with a request pending
        for (int i = 0; i < 3; i++) begin
            step();
            check("rst_outs", 32'({req, rnw, addr, wr_data, gpio_cs, disp_cs, uart_cs}), 32'd0);
            check("rst_m0", 32'(mout(0)), 32'd0);
            check("rst_m1", 32'(mout(1)), 32'd0);
        end
        m0_req = 1'b0;
        reset  = 1'b0;
        prio_m1 = 0;
        step();

        // simultaneous requests, four times: m0,m1,m0,m1,...
        for (int i = 0; i < 4; i++) begin
            new_targets();
            run_round(2'b11, rand_tx(), rand_tx());
        end

        // m0 read of gpio offset 0x12, ready after 2 cycles, data 0xA5
        new_targets();
        tgt_rd[0] = 8'hA5;
        run_round(2'b01, mk(1'b1, 10'h012, 8'h00, 2), rand_tx());

        // m1 write to uart offset 0x03, data 0x5C, ready immediately
        new_targets();
        run_round(2'b10, rand_tx(), mk(1'b0, 10'h203, 8'h5C, 0));

        // m0 read of the unmapped range
        new_targets();
        run_round(2'b01, mk(1'b1, 10'h377, 8'h00, 0), rand_tx());

        // reset while BUSY: m0 served last, so m1 would win a tie without reset
        new_targets();
        run_round(2'b01, mk(1'b0, 10'h040, 8'h11, 0), rand_tx());
        set_m(0, 1'b1, mk(1'b1, 10'h044, 8'h00, 0));
        drive_rdy(2'd0, 1'b0);
        step();
        drive_rdy(2'd0, 1'b0);
        step();
        check("pre_rst_req", 32'(req), 32'd1);
        #1 reset = 1'b1;
        #1;
        check("rst_busy_req", 32'(req), 32'd0);
        check("rst_busy_cs", 32'({uart_cs, disp_cs, gpio_cs}), 32'd0);
        check("rst_busy_m0", 32'(mout(0)), 32'd0);
        m0_req  = 1'b0;
        prio_m1 = 0;
        #2 reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("post_rst_req", 32'(req), 32'd0);
            check("post_rst_m0", 32'(mout(0)), 32'd0);
        end
        new_targets();
        run_round(2'b10, rand_tx(), rand_tx());
        new_targets();
        run_round(2'b11, rand_tx(), rand_tx());

        // randomized rounds
        for (int r = 0; r < 40; r++) begin
            new_targets();
            run_round(2'($urandom_range(1, 3)), rand_tx(), rand_tx());
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/local_bus_arb.md
LOCAL_BUS_ARB -- requirements
Module: local_bus_arb

Interface
REQ-001 SHALL have port clk, input, 1: sole clock; all state on rising edge.
REQ-002 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-003 SHALL have ports m0_req / m1_req, input, 1: level request, held until matching ack.
REQ-004 SHALL have ports m0_rnw / m1_rnw, input, 1: 1=read, 0=write.
REQ-005 SHALL have ports m0_addr / m1_addr, input, 10: [9:8] target select (0 gpio, 1 disp, 2 uart, 3 unmapped), [7:0] register offset.
REQ-006 SHALL have ports m0_wr_data / m1_wr_data, input, 8: write data.
REQ-007 SHALL have ports m0_ack / m1_ack, output, 1: one-cycle completion pulse.
REQ-008 SHALL have ports m0_err / m1_err, output, 1: valid with ack; 1 = timeout or unmapped.
REQ-009 SHALL have ports m0_rd_data / m1_rd_data, output, 8: read data, valid with ack.
REQ-010 SHALL have ports addr (out 8), rnw (out 1), req (out 1), wr_data (out 8): local IO bus.
REQ-011 SHALL have ports gpio_cs, disp_cs, uart_cs (out 1) and gpio_rdy, disp_rdy, uart_rdy (in 1), gpio_rd_data, disp_rd_data, uart_rd_data (in 8).

Function
REQ-012 SHALL implement FSM IDLE -> BUSY -> ACK -> IDLE.
REQ-013 IDLE: if any mN_req=1, grant one master at next edge, latch its rnw/addr/wr_data, enter BUSY; else stay.
REQ-014 Both requests in IDLE: round-robin; the master not granted last wins; after reset m0 wins.
REQ-015 BUSY: drive req=1, registered addr/rnw/wr_data, exactly one cs per latched select; sel=3 drives no cs.
REQ-016 BUSY: on edge where selected rdy=1, capture that module's rd_data (reads only; writes capture 0x00), set err=0, enter ACK.
REQ-017 ACK: granted mN_ack=1 for exactly one cycle with rd_data/err; req and all cs=0; requests ignored; return IDLE; update round-robin pointer.
REQ-018 Requester SHALL drop req at the edge leaving ACK; req still high in IDLE is a new transaction.
REQ-019 Minimum latency: req high in IDLE at edge 0, rdy already high -> BUSY edge 1, ACK edge 2, ack visible cycle 2-3 (3 cycles request-to-ack).
REQ-020 rdy from non-selected modules SHALL be ignored; changes of mN_addr/wr_data during BUSY SHALL not affect bus.
REQ-021 Non-granted master's ack, err, rd_data SHALL stay 0.

Reset
REQ-022 reset=1 SHALL immediately force IDLE, all outputs 0, pointer to m0 priority, timeout counter 0, including mid-BUSY; aborted transaction gets no ack.

Configuration
REQ-023 Macro LOCAL_BUS_ARB_TIMEOUT_EN defined: 10-bit counter cleared on BUSY entry, increments each BUSY cycle; at 1023 without rdy -> ACK with err=1, rd_data=0x00; sel=3 times out identically.
REQ-024 Macro undefined: no counter; sel=3 goes BUSY -> ACK after one BUSY cycle with err=1; mapped target waits indefinitely for rdy.

Structure
REQ-025 Package local_bus_pkg SHALL hold FSM state typedef, target-select codes, TIMEOUT_MAX=1023.
REQ-026 Round-robin grant SHALL be sub-module local_bus_rr_arb (2 requests, pointer update input, one-hot grant).

Verification
REQ-027 m0 read sel=0 off 0x12, gpio_rdy=1 after 2 cycles, gpio_rd_data=0xA5 -> gpio_cs, addr=0x12, rnw=1, m0_ack pulse, m0_rd_data=0xA5, m0_err=0.
REQ-028 m0 and m1 req same cycle, repeat 4x -> grants m0,m1,m0,m1; no overlapping cs.
REQ-029 m1 write sel=2 off 0x03 data 0x5C, uart_rdy=1 -> uart_cs, rnw=0, wr_data=0x5C, m1_ack, m1_rd_data=0x00.
REQ-030 TIMEOUT_EN: m0 sel=3 read -> m0_ack after 1023 BUSY cycles, m0_err=1, rd_data=0x00; without macro -> ack after 1 BUSY cycle, err=1.
REQ-031 reset pulsed in BUSY -> same cycle req=0, cs=0, no ack; next m1-only request granted normally; simultaneous request then goes to m0.
